fetch_unit: RTL and testbench
=============================

# fetch_unit

Dual-issue instruction fetch initiator that drives the instruction-ROM read port (`imem_ren`, `imem_addr0/1`) and consumes its registered 1-cycle response (`imem_valid`, `imem_rdata0/1`, `imem_pc`). It buffers fetched instructions in a small circular fetch queue and presents up to two per cycle to decode. It also handles front-end redirects (branch/exception PC changes) by flushing the queue and discarding stale responses.

## Interface
- `XLEN`, 32: data and address width.
- `RESET_PC`, 32'h0: PC loaded on reset.
- `FQ_DEPTH`, 8: fetch-queue entries, one instruction each; power of two, ≥4.
- `IMEM_BYTES`, 8192: instruction memory size; used only under `FETCH_ADDR_CHECK_EN`.
- `clk` in 1: the only clock; all state on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_ren` out 1: read request to the instruction ROM.
- `imem_addr0` out XLEN: equals the PC.
- `imem_addr1` out XLEN: equals PC+4.
- `imem_valid` in 1: ROM response valid.
- `imem_rdata0`, `imem_rdata1` in XLEN: instructions at addr0 and addr1.
- `imem_pc` in 2×XLEN: echoed addresses; queued as each instruction's PC.
- `redirect_valid` in 1: flush the front end and restart at `redirect_pc`.
- `redirect_pc` in XLEN: new fetch PC.
- `dec_valid` out 2: bit0 = slot0 valid, bit1 = slot1 valid.
- `dec_instr` out 2×XLEN: queue head and head+1 instructions.
- `dec_pc` out 2×XLEN: PCs of those instructions.
- `dec_take` in 2: number of instructions decode consumes this cycle (0–2).
- `fetch_fault` out 1: sticky address fault; constant 0 unless the macro is defined.

## Operation
- State:
  - `pc`: fetch PC.
  - `req_pending`: a request was issued last cycle.
  - `epoch` bit: toggles on redirect.
  - `fault`: the sticky address fault.
  - Queue: head, tail, `count`, where `count` is `$clog2(FQ_DEPTH)+1` bits wide.
- Request rule: `imem_ren = !reset && !redirect_valid && !fault && (FQ_DEPTH - count - (req_pending ? 2 : 0) >= 2)`.
  - `count` is the registered value; the rule is deliberately conservative, ignoring same-cycle pops.
- When a request issues: `pc <= pc + 8`, with XLEN-bit modulo wrap. Addresses are always a pair, pc and pc+4.
- Response acceptance:
  - A response is pushed only when `req_pending && imem_valid && !redirect_valid`.
  - `imem_valid` alone is never trusted, because the ROM holds it high after its first read.
  - Push writes two entries {rdata0, pc[0]} then {rdata1, pc[1]} at the tail.
- Pop: `dec_take` entries leave at the head.
  - `dec_take` > valid count, or `dec_take` = 3, is illegal and is flagged by assertion.
  - A push and a pop in the same cycle are legal: `count <= count + push*2 - take`.
- Full/empty: the request rule guarantees push never overflows. `count==0` gives `dec_valid=2'b00`; `count==1` gives `2'b01`.
- Redirect, which has the highest priority:
  - Queue is emptied (head = tail, count = 0) and `dec_take` is ignored.
  - `req_pending` is cleared; a response arriving the next cycle is dropped.
  - `pc <= redirect_pc`, `fault` is cleared, and `epoch` toggles.
  - No request issues in the redirect cycle itself.
- Pointers wrap modulo `FQ_DEPTH`.

## Timing
- Reset values, next edge:
  - `pc = RESET_PC`; `count`, head and tail = 0; `req_pending = 0`; `fault = 0`.
  - Outputs: `dec_valid = 0`, `dec_instr = 0`, `dec_pc = 0`.
  - `imem_ren` is 0 while `reset` is high.
- Reset mid-operation discards all queued and in-flight data.
- Latency: request in cycle N → ROM data valid in N+1 → pushed at the end of N+1 → `dec_valid` in N+2. There is no bypass.
- Redirect in cycle R → first new request in R+1 → first instruction at decode in R+3.
- Steady state with `dec_take=2`: 2 instructions/cycle sustained; a request issues every cycle.

## Configuration
- `FETCH_ADDR_CHECK_EN` defined:
  - Before requesting, check that `pc[1:0]==0` and `pc+4 < IMEM_BYTES`.
  - On failure: no request issues and `fault` is set.
  - `fetch_fault` stays high until reset or redirect. Queued entries still drain.
- Not defined: no checks are made, `fetch_fault` is tied to 0, and addresses pass through unchanged.

## Structure
- `core_pkg` holds:
  - `fetch_entry_t` {instr, pc}.
  - `FQ_DEPTH_DEFAULT`.
  - The NOP encoding 32'hFFFF_FFFF, used by benches as filler.
- Sub-module `fetch_queue`: a circular buffer with 2-wide push, 0–2 pop, flush, and count output.
- `fetch_unit` holds the PC, the request/credit logic, the epoch and the fault.

## Test plan
- Release reset with `dec_take=2` held:
  - First cycle: `imem_ren=1`, addr0=0x0, addr1=0x4.
  - Two cycles later: `dec_valid=11`, `dec_pc` = 0x0/0x4.
  - Then 0x8/0xC on the next cycle, and so on.
- `dec_take=0` from reset: exactly 4 requests issue, then `imem_ren=0`. `count=8`, with PCs 0x0–0x1C queued in order.
- Full queue, then `dec_take=1` for one cycle: `count=7` and no request (free=1). `dec_take=2` then reopens requests.
- `redirect_valid` with `redirect_pc=0x100` the cycle after a request:
  - The in-flight response is dropped and `dec_valid=00`.
  - The next request is addr0=0x100, addr1=0x104.
- Redirect asserted together with `dec_take=2` on a full queue: the take is ignored, `count=0` on the next cycle, and there is no overflow or underflow.
- With the macro defined and `IMEM_BYTES=8192`: redirect to 0x2000 → no request and `fetch_fault=1`. A redirect to 0x10 clears it and requests 0x10/0x14.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the fetch front end.
package core_pkg;

    localparam int CORE_XLEN        = 32;
    localparam int FQ_DEPTH_DEFAULT = 8;

    // All-ones word used as filler on the instruction-ROM data lines
    localparam logic [CORE_XLEN-1:0] NOP_INSTR = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [CORE_XLEN-1:0] instr;
        logic [CORE_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: two entries pushed at once, zero to two popped per
// cycle, single-cycle flush. Slots that hold no instruction read as zero.
module fetch_queue
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [XLEN-1:0]   push_instr0,
    input  logic [XLEN-1:0]   push_instr1,
    input  logic [XLEN-1:0]   push_pc0,
    input  logic [XLEN-1:0]   push_pc1,
    input  logic [1:0]        take,
    output logic [1:0]        head_valid,
    output logic [2*XLEN-1:0] head_instr,
    output logic [2*XLEN-1:0] head_pc,
    output logic [CW-1:0]     count
);

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count_q;

    assign count = count_q;

    // Pointer and occupancy update; flush wins over any push or pop
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(2);
            end
            head    <= head + PW'(take);
            count_q <= count_q + (push ? CW'(2) : CW'(0)) - CW'(take);
        end
    end

    // Storage write of the instruction pair at the tail
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            instr_mem[tail]          <= push_instr0;
            pc_mem[tail]             <= push_pc0;
            instr_mem[tail + PW'(1)] <= push_instr1;
            pc_mem[tail + PW'(1)]    <= push_pc1;
        end
    end

    // Present head and head+1, masking empty slots to zero
    always_comb begin
        head_valid = {(count_q >= CW'(2)), (count_q >= CW'(1))};
        head_instr = '0;
        head_pc    = '0;
        if (head_valid[0]) begin
            head_instr[XLEN-1:0] = instr_mem[head];
            head_pc[XLEN-1:0]    = pc_mem[head];
        end
        if (head_valid[1]) begin
            head_instr[2*XLEN-1:XLEN] = instr_mem[head + PW'(1)];
            head_pc[2*XLEN-1:XLEN]    = pc_mem[head + PW'(1)];
        end
    end

    take_legal: assert property (@(posedge clk) disable iff (reset || flush)
        (take != 2'd3) && (CW'(take) <= count_q));

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue instruction fetch: PC, request credit, epoch and fault handling.
// Optional feature macro: FETCH_ADDR_CHECK_EN (alignment/range check on PC).
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FQ_DEPTH   = FQ_DEPTH_DEFAULT,
    parameter int              IMEM_BYTES = 8192
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_ren,
    output logic [XLEN-1:0]   imem_addr0,
    output logic [XLEN-1:0]   imem_addr1,
    input  logic              imem_valid,
    input  logic [XLEN-1:0]   imem_rdata0,
    input  logic [XLEN-1:0]   imem_rdata1,
    input  logic [2*XLEN-1:0] imem_pc,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [1:0]        dec_valid,
    output logic [2*XLEN-1:0] dec_instr,
    output logic [2*XLEN-1:0] dec_pc,
    input  logic [1:0]        dec_take,
    output logic              fetch_fault
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic            req_pending;
    logic            epoch;
    logic            req_epoch;
    logic            fault;
    logic [CW-1:0]   count;
    logic            credit_ok;
    logic            addr_ok;
    logic            issue;
    logic            accept;

    // Credit: room for the pair already in flight plus one more pair
    always_comb begin
        credit_ok = (FQ_DEPTH - int'(count) - (req_pending ? 2 : 0)) >= 2;
    end

`ifdef FETCH_ADDR_CHECK_EN
    logic [XLEN:0] pc_end;

    // The pair must be word aligned and fit entirely below the ROM top
    always_comb begin
        pc_end  = {1'b0, pc} + (XLEN+1)'(4);
        addr_ok = (pc[1:0] == 2'b00) && (pc_end < (XLEN+1)'(IMEM_BYTES));
    end

    // Sticky fault, cleared only by reset or a redirect
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            fault <= 1'b0;
        end else if (!fault && credit_ok && !addr_ok) begin
            fault <= 1'b1;
        end
    end
`else
    assign addr_ok = 1'b1;
    assign fault   = 1'b0;
`endif

    assign issue       = !reset && !redirect_valid && !fault && credit_ok && addr_ok;
    assign imem_ren    = issue;
    assign imem_addr0  = pc;
    assign imem_addr1  = pc + XLEN'(4);
    assign fetch_fault = fault;

    // The ROM keeps imem_valid high, so only our own tagged request is accepted
    assign accept = req_pending && imem_valid && !redirect_valid && (req_epoch == epoch);

    // PC, outstanding-request flag and epoch; redirect outranks issuing
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            req_pending <= 1'b0;
            req_epoch   <= 1'b0;
            epoch       <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            req_pending <= 1'b0;
            epoch       <= ~epoch;
        end else begin
            req_pending <= issue;
            if (issue) begin
                pc        <= pc + XLEN'(8);
                req_epoch <= epoch;
            end
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush       (redirect_valid),
        .push        (accept),
        .push_instr0 (imem_rdata0),
        .push_instr1 (imem_rdata1),
        .push_pc0    (imem_pc[XLEN-1:0]),
        .push_pc1    (imem_pc[2*XLEN-1:XLEN]),
        .take        (dec_take),
        .head_valid  (dec_valid),
        .head_instr  (dec_instr),
        .head_pc     (dec_pc),
        .count       (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural ROM, a stream-level model
// of expected fetches, and a monitor comparing every cycle.
module tb_fetch_unit;
    import core_pkg::*;

    localparam int DEPTH = 8;
    localparam int IMEM  = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ren;
    logic [31:0] imem_addr0, imem_addr1;
    logic        imem_valid;
    logic [31:0] imem_rdata0, imem_rdata1;
    logic [63:0] imem_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  dec_valid;
    logic [63:0] dec_instr, dec_pc;
    logic [1:0]  dec_take;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(DEPTH), .IMEM_BYTES(IMEM)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_ren(imem_ren), .imem_addr0(imem_addr0), .imem_addr1(imem_addr1),
        .imem_valid(imem_valid), .imem_rdata0(imem_rdata0), .imem_rdata1(imem_rdata1),
        .imem_pc(imem_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .dec_take(dec_take), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    // ROM: registered one-cycle response, valid held high once it has read
    logic        rom_req = 1'b0;
    logic [31:0] rom_a0, rom_a1;
    always @(negedge clk) begin
        rom_req = imem_ren;
        rom_a0  = imem_addr0;
        rom_a1  = imem_addr1;
    end
    always @(posedge clk) begin
        if (rom_req) begin
            imem_valid  <= 1'b1;
            imem_rdata0 <= instr_of(rom_a0);
            imem_rdata1 <= instr_of(rom_a1);
            imem_pc     <= {rom_a1, rom_a0};
        end
    end

    // Reference model: expected decode stream and next fetch address
    fetch_entry_t sb[$];
    logic        infl       = 1'b0;
    logic [31:0] infl_addr  = '0;
    logic [31:0] exp_addr   = '0;
    logic        exp_fault  = 1'b0;
    bit          armed      = 1'b0;
    bit          after_rst  = 1'b0;

    function automatic bit model_addr_ok(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
        return (a[1:0] == 2'b00) && ({1'b0, a} + 33'd4 < 33'(IMEM));
`else
        return (a == a);
`endif
    endfunction

    function automatic bit model_credit();
        return (DEPTH - sb.size() - (infl ? 2 : 0)) >= 2;
    endfunction

    function automatic bit model_ren();
        return !reset && !redirect_valid && !exp_fault && model_credit() && model_addr_ok(exp_addr);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the model state for this cycle
    always @(negedge clk) begin
        int n;
        bit eren;
        logic [1:0] ev;
        checkOutput("ren_in_reset_or_cycle", {63'd0, imem_ren}, {63'd0, armed ? model_ren() : 1'b0});
        if (armed && !reset) begin
            n  = sb.size();
            ev = (n >= 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
            checkOutput("dec_valid", {62'd0, dec_valid}, {62'd0, ev});
            if (n >= 1) begin
                checkOutput("dec_pc0", {32'd0, dec_pc[31:0]}, {32'd0, sb[0].pc});
                checkOutput("dec_instr0", {32'd0, dec_instr[31:0]}, {32'd0, sb[0].instr});
            end
            if (n >= 2) begin
                checkOutput("dec_pc1", {32'd0, dec_pc[63:32]}, {32'd0, sb[1].pc});
                checkOutput("dec_instr1", {32'd0, dec_instr[63:32]}, {32'd0, sb[1].instr});
            end
            if (after_rst) begin
                checkOutput("reset_dec_instr", dec_instr, 64'd0);
                checkOutput("reset_dec_pc", dec_pc, 64'd0);
            end
            eren = model_ren();
            if (eren) begin
                checkOutput("imem_addr0", {32'd0, imem_addr0}, {32'd0, exp_addr});
                checkOutput("imem_addr1", {32'd0, imem_addr1}, {32'd0, exp_addr + 32'd4});
            end
            checkOutput("fetch_fault", {63'd0, fetch_fault}, {63'd0, exp_fault});
        end
    end

    // Model update for the coming edge, after the monitor has compared
    always @(negedge clk) begin
        bit eren;
        #1;
        eren = model_ren();
        if (reset) begin
            sb.delete();
            infl      = 1'b0;
            exp_addr  = 32'h0;
            exp_fault = 1'b0;
            armed     = 1'b1;
            after_rst = 1'b1;
        end else if (redirect_valid) begin
            sb.delete();
            infl      = 1'b0;
            exp_addr  = redirect_pc;
            exp_fault = 1'b0;
            after_rst = 1'b0;
        end else begin
            for (int i = 0; i < int'(dec_take); i++) begin
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (infl) begin
                sb.push_back('{instr: instr_of(infl_addr), pc: infl_addr});
                sb.push_back('{instr: instr_of(infl_addr + 32'd4), pc: infl_addr + 32'd4});
            end
            infl = eren;
            if (eren) begin
                infl_addr = exp_addr;
                exp_addr  = exp_addr + 32'd8;
            end else if (!exp_fault && model_credit() && !model_addr_ok(exp_addr)) begin
                exp_fault = 1'b1;
            end
            after_rst = 1'b0;
        end
    end

    // Drive one cycle of inputs, clamping the take to what decode holds
    task automatic applyStimulus(input logic rst, input int want, input logic redir, input logic [31:0] rpc);
        int avail;
        @(posedge clk);
        #1;
        avail          = (sb.size() >= 2) ? 2 : sb.size();
        reset          = rst;
        dec_take       = 2'(rst ? 0 : ((want < avail) ? want : avail));
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    initial begin
        int reqs;
        reset          = 1'b1;
        dec_take       = 2'd0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_valid     = 1'b0;
        imem_rdata0    = NOP_INSTR;
        imem_rdata1    = NOP_INSTR;
        imem_pc        = '0;

        repeat (3) applyStimulus(1'b1, 2, 1'b0, '0);
        repeat (20) applyStimulus(1'b0, 2, 1'b0, '0);

        // From reset with no takes: exactly four requests fill the queue
        repeat (2) applyStimulus(1'b1, 0, 1'b0, '0);
        reqs = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 0, 1'b0, '0);
            #1;
            if (imem_ren) reqs++;
        end
        checkOutput("requests_until_full", 64'(reqs), 64'd4);
        checkOutput("full_dec_valid", {62'd0, dec_valid}, 64'd3);

        applyStimulus(1'b0, 1, 1'b0, '0);
        repeat (8) applyStimulus(1'b0, 2, 1'b0, '0);

        // Redirect the cycle after a request
        applyStimulus(1'b0, 2, 1'b1, 32'h100);
        repeat (8) applyStimulus(1'b0, 2, 1'b0, '0);

        // Redirect on a full queue with a take of two
        repeat (10) applyStimulus(1'b0, 0, 1'b0, '0);
        applyStimulus(1'b0, 2, 1'b1, 32'h40);
        repeat (6) applyStimulus(1'b0, 2, 1'b0, '0);

        // PC wrap across the top of the address space
        applyStimulus(1'b0, 2, 1'b1, 32'hFFFF_FFF0);
        repeat (10) applyStimulus(1'b0, 2, 1'b0, '0);

        // Randomised traffic with occasional redirects and resets
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)
                applyStimulus(1'b1, 0, 1'b0, '0);
            else if (r < 10)
                applyStimulus(1'b0, $urandom_range(0, 2), 1'b1, 32'($urandom_range(0, 1023)) << 2);
            else
                applyStimulus(1'b0, $urandom_range(0, 2), 1'b0, '0);
        end

`ifdef FETCH_ADDR_CHECK_EN
        applyStimulus(1'b0, 2, 1'b1, 32'h2000);
        repeat (3) applyStimulus(1'b0, 2, 1'b0, '0);
        checkOutput("fault_set", {63'd0, fetch_fault}, 64'd1);
        applyStimulus(1'b0, 2, 1'b1, 32'h10);
        applyStimulus(1'b0, 2, 1'b0, '0);
        #1;
        checkOutput("fault_cleared", {63'd0, fetch_fault}, 64'd0);
        checkOutput("refetch_addr0", {32'd0, imem_addr0}, 64'h10);
        repeat (4) applyStimulus(1'b0, 2, 1'b0, '0);
`endif

        repeat (3) applyStimulus(1'b0, 2, 1'b0, '0);
        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
